// File: rtl/mos6502_pkg.sv
// Shared 6502 definitions: mnemonic and addressing-mode indices, instruction
// length by mode, and the encoder state type.
package mos6502_pkg;

    typedef enum logic [5:0] {
        MNEM_ADC, MNEM_AND, MNEM_ASL, MNEM_BCC, MNEM_BCS, MNEM_BEQ, MNEM_BIT, MNEM_BMI,
        MNEM_BNE, MNEM_BPL, MNEM_BRK, MNEM_BVC, MNEM_BVS, MNEM_CLC, MNEM_CLD, MNEM_CLI,
        MNEM_CLV, MNEM_CMP, MNEM_CPX, MNEM_CPY, MNEM_DEC, MNEM_DEX, MNEM_DEY, MNEM_EOR,
        MNEM_INC, MNEM_INX, MNEM_INY, MNEM_JMP, MNEM_JSR, MNEM_LDA, MNEM_LDX, MNEM_LDY,
        MNEM_LSR, MNEM_NOP, MNEM_ORA, MNEM_PHA, MNEM_PHP, MNEM_PLA, MNEM_PLP, MNEM_ROL,
        MNEM_ROR, MNEM_RTI, MNEM_RTS, MNEM_SBC, MNEM_SEC, MNEM_SED, MNEM_SEI, MNEM_STA,
        MNEM_STX, MNEM_STY, MNEM_TAX, MNEM_TAY, MNEM_TSX, MNEM_TXA, MNEM_TXS, MNEM_TYA
    } mnem_e;

    typedef enum logic [3:0] {
        MODE_IMP, MODE_ACC, MODE_IMM, MODE_ZPG, MODE_ZPGX, MODE_ZPGY, MODE_ABS,
        MODE_ABSX, MODE_ABSY, MODE_IND, MODE_XIND, MODE_INDY, MODE_REL
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_OPC, ST_LO, ST_HI
    } enc_state_e;

    // Total instruction length in bytes; 0 for mode indices that do not exist.
    function automatic logic [1:0] mode_len(input logic [3:0] mode);
        logic [1:0] len;
        case (mode)
            MODE_IMP, MODE_ACC:                               len = 2'd1;
            MODE_IMM, MODE_ZPG, MODE_ZPGX, MODE_ZPGY,
            MODE_XIND, MODE_INDY, MODE_REL:                   len = 2'd2;
            MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND:         len = 2'd3;
            default:                                          len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mos6502_opcode_rom.sv
// Combinational (mnemonic, mode) -> {legal, opcode} table for the documented
// 6502 instruction set. Anything not in the table is reported illegal.
module mos6502_opcode_rom
    import mos6502_pkg::*;
(
    input  logic [5:0] mnem,
    input  logic [3:0] mode,
    output logic       legal,
    output logic [7:0] opcode
);

    // ALU group (ORA/AND/EOR/ADC/STA/LDA/CMP/SBC) shares one mode->offset map;
    // STA has no immediate form.
    function automatic logic [8:0] alu_op(input logic [7:0] base, input logic [3:0] m,
                                          input logic no_imm);
        logic [8:0] r;
        case (m)
            MODE_XIND: r = {1'b1, base | 8'h01};
            MODE_ZPG:  r = {1'b1, base | 8'h05};
            MODE_IMM:  r = {!no_imm, base | 8'h09};
            MODE_ABS:  r = {1'b1, base | 8'h0D};
            MODE_INDY: r = {1'b1, base | 8'h11};
            MODE_ZPGX: r = {1'b1, base | 8'h15};
            MODE_ABSY: r = {1'b1, base | 8'h19};
            MODE_ABSX: r = {1'b1, base | 8'h1D};
            default:   r = 9'd0;
        endcase
        return r;
    endfunction

    // Shift/rotate group (ASL/ROL/LSR/ROR).
    function automatic logic [8:0] shift_op(input logic [7:0] base, input logic [3:0] m);
        logic [8:0] r;
        case (m)
            MODE_ACC:  r = {1'b1, base | 8'h0A};
            MODE_ZPG:  r = {1'b1, base | 8'h06};
            MODE_ZPGX: r = {1'b1, base | 8'h16};
            MODE_ABS:  r = {1'b1, base | 8'h0E};
            MODE_ABSX: r = {1'b1, base | 8'h1E};
            default:   r = 9'd0;
        endcase
        return r;
    endfunction

    // Single-mode instructions: legal only in the one mode they exist in.
    function automatic logic [8:0] only(input logic [7:0] op, input logic [3:0] m,
                                        input logic [3:0] want);
        return {m == want, op};
    endfunction

    // Table lookup.
    always_comb begin
        logic [8:0] r;
        r = 9'd0;
        case (mnem)
            MNEM_ORA: r = alu_op(8'h00, mode, 1'b0);
            MNEM_AND: r = alu_op(8'h20, mode, 1'b0);
            MNEM_EOR: r = alu_op(8'h40, mode, 1'b0);
            MNEM_ADC: r = alu_op(8'h60, mode, 1'b0);
            MNEM_STA: r = alu_op(8'h80, mode, 1'b1);
            MNEM_LDA: r = alu_op(8'hA0, mode, 1'b0);
            MNEM_CMP: r = alu_op(8'hC0, mode, 1'b0);
            MNEM_SBC: r = alu_op(8'hE0, mode, 1'b0);
            MNEM_ASL: r = shift_op(8'h00, mode);
            MNEM_ROL: r = shift_op(8'h20, mode);
            MNEM_LSR: r = shift_op(8'h40, mode);
            MNEM_ROR: r = shift_op(8'h60, mode);
            MNEM_INC, MNEM_DEC: begin
                case (mode)
                    MODE_ZPG:  r = {1'b1, 8'hC6};
                    MODE_ZPGX: r = {1'b1, 8'hD6};
                    MODE_ABS:  r = {1'b1, 8'hCE};
                    MODE_ABSX: r = {1'b1, 8'hDE};
                    default:   r = 9'd0;
                endcase
                if (mnem == MNEM_INC) r[7:0] = r[7:0] | 8'h20;
            end
            MNEM_LDX: begin
                case (mode)
                    MODE_IMM:  r = {1'b1, 8'hA2};
                    MODE_ZPG:  r = {1'b1, 8'hA6};
                    MODE_ZPGY: r = {1'b1, 8'hB6};
                    MODE_ABS:  r = {1'b1, 8'hAE};
                    MODE_ABSY: r = {1'b1, 8'hBE};
                    default:   r = 9'd0;
                endcase
            end
            MNEM_LDY: begin
                case (mode)
                    MODE_IMM:  r = {1'b1, 8'hA0};
                    MODE_ZPG:  r = {1'b1, 8'hA4};
                    MODE_ZPGX: r = {1'b1, 8'hB4};
                    MODE_ABS:  r = {1'b1, 8'hAC};
                    MODE_ABSX: r = {1'b1, 8'hBC};
                    default:   r = 9'd0;
                endcase
            end
            MNEM_STX: begin
                case (mode)
                    MODE_ZPG:  r = {1'b1, 8'h86};
                    MODE_ZPGY: r = {1'b1, 8'h96};
                    MODE_ABS:  r = {1'b1, 8'h8E};
                    default:   r = 9'd0;
                endcase
            end
            MNEM_STY: begin
                case (mode)
                    MODE_ZPG:  r = {1'b1, 8'h84};
                    MODE_ZPGX: r = {1'b1, 8'h94};
                    MODE_ABS:  r = {1'b1, 8'h8C};
                    default:   r = 9'd0;
                endcase
            end
            MNEM_CPX, MNEM_CPY: begin
                case (mode)
                    MODE_IMM:  r = {1'b1, 8'hC0};
                    MODE_ZPG:  r = {1'b1, 8'hC4};
                    MODE_ABS:  r = {1'b1, 8'hCC};
                    default:   r = 9'd0;
                endcase
                if (mnem == MNEM_CPX) r[7:0] = r[7:0] | 8'h20;
            end
            MNEM_BIT: begin
                case (mode)
                    MODE_ZPG:  r = {1'b1, 8'h24};
                    MODE_ABS:  r = {1'b1, 8'h2C};
                    default:   r = 9'd0;
                endcase
            end
            MNEM_JMP: begin
                case (mode)
                    MODE_ABS:  r = {1'b1, 8'h4C};
                    MODE_IND:  r = {1'b1, 8'h6C};
                    default:   r = 9'd0;
                endcase
            end
            MNEM_JSR: r = only(8'h20, mode, MODE_ABS);
            MNEM_BPL: r = only(8'h10, mode, MODE_REL);
            MNEM_BMI: r = only(8'h30, mode, MODE_REL);
            MNEM_BVC: r = only(8'h50, mode, MODE_REL);
            MNEM_BVS: r = only(8'h70, mode, MODE_REL);
            MNEM_BCC: r = only(8'h90, mode, MODE_REL);
            MNEM_BCS: r = only(8'hB0, mode, MODE_REL);
            MNEM_BNE: r = only(8'hD0, mode, MODE_REL);
            MNEM_BEQ: r = only(8'hF0, mode, MODE_REL);
            MNEM_BRK: r = only(8'h00, mode, MODE_IMP);
            MNEM_CLC: r = only(8'h18, mode, MODE_IMP);
            MNEM_CLD: r = only(8'hD8, mode, MODE_IMP);
            MNEM_CLI: r = only(8'h58, mode, MODE_IMP);
            MNEM_CLV: r = only(8'hB8, mode, MODE_IMP);
            MNEM_DEX: r = only(8'hCA, mode, MODE_IMP);
            MNEM_DEY: r = only(8'h88, mode, MODE_IMP);
            MNEM_INX: r = only(8'hE8, mode, MODE_IMP);
            MNEM_INY: r = only(8'hC8, mode, MODE_IMP);
            MNEM_NOP: r = only(8'hEA, mode, MODE_IMP);
            MNEM_PHA: r = only(8'h48, mode, MODE_IMP);
            MNEM_PHP: r = only(8'h08, mode, MODE_IMP);
            MNEM_PLA: r = only(8'h68, mode, MODE_IMP);
            MNEM_PLP: r = only(8'h28, mode, MODE_IMP);
            MNEM_RTI: r = only(8'h40, mode, MODE_IMP);
            MNEM_RTS: r = only(8'h60, mode, MODE_IMP);
            MNEM_SEC: r = only(8'h38, mode, MODE_IMP);
            MNEM_SED: r = only(8'hF8, mode, MODE_IMP);
            MNEM_SEI: r = only(8'h78, mode, MODE_IMP);
            MNEM_TAX: r = only(8'hAA, mode, MODE_IMP);
            MNEM_TAY: r = only(8'hA8, mode, MODE_IMP);
            MNEM_TSX: r = only(8'hBA, mode, MODE_IMP);
            MNEM_TXA: r = only(8'h8A, mode, MODE_IMP);
            MNEM_TXS: r = only(8'h9A, mode, MODE_IMP);
            MNEM_TYA: r = only(8'h98, mode, MODE_IMP);
            default:  r = 9'd0;
        endcase
        legal  = r[8];
        opcode = r[7:0];
    end

endmodule

// File: rtl/mos6502_instr_encoder.sv
// Encodes (mnemonic, mode, operand) into a 1-3 byte little-endian 6502
// instruction stream with valid/ready handshakes on both sides.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | ready for a request; illegal requests pulse err here
//   ST_OPC  | presenting opcode byte (out_first)
//   ST_LO   | presenting operand[7:0]
//   ST_HI   | presenting operand[15:8] (3-byte modes only)
module mos6502_instr_encoder
    import mos6502_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_mnem,
    input  logic [3:0]       in_mode,
    input  logic [15:0]      in_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_first,
    output logic             out_last,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    enc_state_e       state_q, state_d;
    logic [7:0]       opcode_q;
    logic [15:0]      operand_q;
    logic [1:0]       len_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rom_legal;
    logic [7:0]       rom_opcode;
    logic             take;
    logic             last_hs;

    mos6502_opcode_rom u_rom (
        .mnem   (in_mnem),
        .mode   (in_mode),
        .legal  (rom_legal),
        .opcode (rom_opcode)
    );

    assign take      = (state_q == ST_IDLE) && in_valid && !reset;
    assign err       = err_q;
    assign instr_cnt = cnt_q;

    // Next state and byte-stream outputs; outputs depend only on registered
    // state so they stay put while the sink stalls.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_first = 1'b0;
        out_last  = 1'b0;
        last_hs   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = !reset;
                if (take && rom_legal) state_d = ST_OPC;
            end
            ST_OPC: begin
                out_valid = 1'b1;
                out_data  = opcode_q;
                out_first = 1'b1;
                out_last  = (len_q == 2'd1);
                if (out_ready) state_d = (len_q == 2'd1) ? ST_IDLE : ST_LO;
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_data  = operand_q[7:0];
                out_last  = (len_q == 2'd2);
                if (out_ready) state_d = (len_q == 2'd2) ? ST_IDLE : ST_HI;
            end
            ST_HI: begin
                out_valid = 1'b1;
                out_data  = operand_q[15:8];
                out_last  = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        last_hs = out_valid && out_ready && out_last;
    end

    // State register, request latch, error pulse and instruction counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 8'h00;
            operand_q <= 16'h0000;
            len_q     <= 2'd0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= take && !rom_legal;
            if (take && rom_legal) begin
                opcode_q  <= rom_opcode;
                operand_q <= in_operand;
                len_q     <= mode_len(in_mode);
            end
            if (last_hs) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
